slowclk_gen: RTL
================

Name: slowclk_gen

Overview:
- Parametrised successor to the fixed 2-bit slow-clock divider.
- Generates a slow square wave `out` and a one-cycle `tick` strobe from the system clock, with a runtime-selectable speed.
- Adds run/pause control and a single-step input, so solver logic can be animated at visible speed or advanced one step at a time from a button.
- Sits between the board switches/buttons and the solver step enable.

Parameters:
- SEL_W, 2, width of the speed-select input; there are 2^SEL_W speeds.
- BASE_LOG2, 10, log2 of the half-period, in clk cycles, at sel=0.
- STEP_LOG2, 5, log2 increment of the half-period per sel step.
- CNT_W, 32, width of the internal counter. Legal only if BASE_LOG2 + STEP_LOG2*(2^SEL_W-1) < CNT_W; violating this is an elaboration error.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- sw  input  SEL_W  speed select.
- en  input  1  1 = run, 0 = pause.
- step  input  1  single-step request, level from a debounced button; edge-detected internally.
- out  output  1  slow square wave, 50% duty.
- tick  output  1  one-cycle strobe, once per slow period or per manual step.

Behaviour:
- Half-period: HALF(s) = 2^(BASE_LOG2 + STEP_LOG2*s) clk cycles, where s = sel_q. Full period is 2*HALF(s).
- Registered state: cnt[CNT_W-1:0], out, tick, sel_q[SEL_W-1:0], step_q.
- Reset (rst=1 at posedge): cnt=0, out=0, tick=0, sel_q=sw, step_q=step. Reset mid-operation aborts the current period with no tick.
- Priority each cycle, highest first: rst, sel change, paused, running.
- sel change (sw != sel_q):
  - sel_q<=sw, cnt<=0, out held, tick=0.
  - Overrides a coincident wrap or step.
  - The new period is measured from this cycle.
- Paused (en=0):
  - cnt frozen, out held.
  - tick=1 for exactly one cycle when step & ~step_q; otherwise tick=0.
  - Holding step high gives a single tick.
- Running (en=1):
  - step is ignored, but step_q still tracks step. Releasing pause while step is held therefore gives no tick.
  - If cnt == HALF-1: cnt<=0 and out<=~out. tick=1 in that same cycle only if out goes 0->1; otherwise tick=0.
  - Else cnt<=cnt+1, tick=0.
- en 0->1: counting resumes from the frozen cnt; no extra tick.
- Timing after reset release, with en=1 and sw constant:
  - out first rises at cycle HALF; tick is high in that cycle.
  - Afterwards out rises and tick pulses every 2*HALF cycles.
- Comparison width: the HALF-1 compare uses CNT_W bits. cnt never exceeds HALF-1, so there is no wrap-around.
- Output timing: all outputs are registered, with zero combinational paths from inputs to outputs.

Test Plan (use SEL_W=2, BASE_LOG2=2, STEP_LOG2=2, giving HALF = 4, 16, 64, 256):
- Reset, then sw=0, en=1 -> out rises at cycle 4 and falls at cycle 8. tick is high at cycles 4, 12, 20, each for 1 cycle.
- Sweep sw=1, 2, 3 with en=1, staying ≥4 periods at each -> tick spacing is 32, 128, 512 cycles; out duty is exactly 50%.
- sw changes 0->2 while cnt=2 and out=1 -> no tick at the change; out stays 1 for 64 cycles, then falls; next rise is 64 cycles later, with tick.
- en=0 at cnt=5 (sw=1), step pulsed 3 times (each held 10 cycles) -> exactly 3 one-cycle ticks; out and cnt unchanged. en=1 -> wrap after 11 further cycles.
- step held high while en=1, then en->0 with step still high -> no tick. Release step, press again -> one tick.
- rst asserted mid-period (sw=3, cnt=100, out=1) -> next cycle out=0, tick=0, cnt=0; first rise 256 cycles after rst drops.

Source files
------------

// File: rtl/slowclk_gen.sv
// Slow-clock generator: a 50% duty square wave plus a one-cycle tick per period,
// with a runtime speed select, run/pause control and a button-driven single step.
module slowclk_gen #(
  parameter int SEL_W     = 2,
  parameter int BASE_LOG2 = 10,
  parameter int STEP_LOG2 = 5,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] sw,
  input  logic             en,
  input  logic             step,
  output logic             out,
  output logic             tick
);

  localparam int NumSel  = 1 << SEL_W;
  localparam int MaxLog2 = BASE_LOG2 + STEP_LOG2 * (NumSel - 1);

  if (MaxLog2 >= CNT_W) begin : g_bad_cnt_w
    $error("slowclk_gen: CNT_W too small for the slowest half-period");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             step_q, step_d;
  logic [CNT_W-1:0] halfM1;

  // Terminal count for the currently latched speed.
  always_comb begin
    halfM1 = '0;
    for (int s = 0; s < NumSel; s++) begin
      if (sel_q == SEL_W'(s)) begin
        halfM1 = (CNT_W'(1) << (BASE_LOG2 + STEP_LOG2 * s)) - CNT_W'(1);
      end
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    tick_d = 1'b0;
    sel_d  = sel_q;
    step_d = step;
    if (sw != sel_q) begin
      sel_d = sw;
      cnt_d = '0;
    end else if (!en) begin
      tick_d = step & ~step_q;
    end else if (cnt_q == halfM1) begin
      cnt_d  = '0;
      out_d  = ~out_q;
      tick_d = ~out_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Reset re-latches the switches and button so no spurious change or step fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      out_q  <= 1'b0;
      tick_q <= 1'b0;
      sel_q  <= sw;
      step_q <= step;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      tick_q <= tick_d;
      sel_q  <= sel_d;
      step_q <= step_d;
    end
  end

  assign out  = out_q;
  assign tick = tick_q;

endmodule
